// File: rtl/rs_alu_pkg.sv
// Shared core definitions: op classes, tag conventions and default sizing
// for the ALU reservation station and its neighbours.
package cpu_defs;

  localparam int RS_SIZE_DEF = 16;
  localparam int Q_WIDTH_DEF = 5;
  localparam int DATA_W      = 32;
  localparam int OP_W        = 10;

  // Tag value meaning "operand already present".
  localparam int Q_NONE = 0;

  typedef enum logic [2:0] {
    OP_R = 3'd1,
    OP_I = 3'd2,
    OP_B = 3'd4,
    OP_U = 3'd5,
    OP_J = 3'd6
  } op_class_e;

endpackage

// File: rtl/rs_alu_if.sv
// Issue, CDB snoop and EX dispatch bundle between the core and the ALU RS.
interface rs_alu_if #(
  parameter int Q_WIDTH = 5
);
  logic               issue_valid_in;
  logic [9:0]         issue_op_in;
  logic [31:0]        issue_V1_in;
  logic [Q_WIDTH-1:0] issue_Q1_in;
  logic [31:0]        issue_V2_in;
  logic [Q_WIDTH-1:0] issue_Q2_in;
  logic [31:0]        issue_imm_in;
  logic [31:0]        issue_npc_in;
  logic [Q_WIDTH-1:0] issue_dest_in;
  logic               full_out;

  logic               alu_cdb_valid_in;
  logic [Q_WIDTH-1:0] alu_cdb_tag_in;
  logic [31:0]        alu_cdb_value_in;
  logic               lsb_cdb_valid_in;
  logic [Q_WIDTH-1:0] lsb_cdb_tag_in;
  logic [31:0]        lsb_cdb_value_in;

  logic               ex_valid_out;
  logic [9:0]         ex_op_out;
  logic [31:0]        ex_V1_out;
  logic [31:0]        ex_V2_out;
  logic [31:0]        ex_imm_out;
  logic [31:0]        ex_npc_out;
  logic [Q_WIDTH-1:0] ex_dest_out;

  modport master (
    output issue_valid_in, issue_op_in, issue_V1_in, issue_Q1_in, issue_V2_in,
           issue_Q2_in, issue_imm_in, issue_npc_in, issue_dest_in,
           alu_cdb_valid_in, alu_cdb_tag_in, alu_cdb_value_in,
           lsb_cdb_valid_in, lsb_cdb_tag_in, lsb_cdb_value_in,
    input  full_out, ex_valid_out, ex_op_out, ex_V1_out, ex_V2_out,
           ex_imm_out, ex_npc_out, ex_dest_out
  );

  modport slave (
    input  issue_valid_in, issue_op_in, issue_V1_in, issue_Q1_in, issue_V2_in,
           issue_Q2_in, issue_imm_in, issue_npc_in, issue_dest_in,
           alu_cdb_valid_in, alu_cdb_tag_in, alu_cdb_value_in,
           lsb_cdb_valid_in, lsb_cdb_tag_in, lsb_cdb_value_in,
    output full_out, ex_valid_out, ex_op_out, ex_V1_out, ex_V2_out,
           ex_imm_out, ex_npc_out, ex_dest_out
  );

endinterface

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module rs_pick #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu.sv
// ALU/branch reservation station: holds renamed ops until both operands are
// present (via issue bypass or CDB wakeup) and dispatches one per cycle.
module rs_alu
  import cpu_defs::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int Q_WIDTH = Q_WIDTH_DEF
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  input  logic     rdy_in,
  input  logic     clear_in,
  rs_alu_if.slave  bus
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam logic [Q_WIDTH-1:0] QZ = Q_WIDTH'(Q_NONE);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] ready_vec;
  logic [OP_W-1:0]    op_q   [RS_SIZE];
  logic [DATA_W-1:0]  v1_q   [RS_SIZE];
  logic [Q_WIDTH-1:0] q1_q   [RS_SIZE];
  logic [DATA_W-1:0]  v2_q   [RS_SIZE];
  logic [Q_WIDTH-1:0] q2_q   [RS_SIZE];
  logic [DATA_W-1:0]  imm_q  [RS_SIZE];
  logic [DATA_W-1:0]  npc_q  [RS_SIZE];
  logic [Q_WIDTH-1:0] dest_q [RS_SIZE];

  logic               vld_p1;
  logic [OP_W-1:0]    op_p1;
  logic [DATA_W-1:0]  v1_p1;
  logic [DATA_W-1:0]  v2_p1;
  logic [DATA_W-1:0]  imm_p1;
  logic [DATA_W-1:0]  npc_p1;
  logic [Q_WIDTH-1:0] dest_p1;

  logic               full;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_found;
  logic [IDX_W-1:0]   disp_idx;
  logic               issue_fire;

  logic               alu_vld;
  logic [Q_WIDTH-1:0] alu_tag;
  logic [DATA_W-1:0]  alu_val;
  logic               lsb_vld;
  logic [Q_WIDTH-1:0] lsb_tag;
  logic [DATA_W-1:0]  lsb_val;

  assign alu_vld = bus.alu_cdb_valid_in;
  assign alu_tag = bus.alu_cdb_tag_in;
  assign alu_val = bus.alu_cdb_value_in;
  assign lsb_vld = bus.lsb_cdb_valid_in;
  assign lsb_tag = bus.lsb_cdb_tag_in;
  assign lsb_val = bus.lsb_cdb_value_in;

  function automatic logic cdb_hit(input logic [Q_WIDTH-1:0] q,
                                   input logic               vld,
                                   input logic [Q_WIDTH-1:0] tag);
    return vld && (tag != QZ) && (q == tag);
  endfunction

  // Returns the resolved {tag, value}; the ALU bus wins if both buses match.
  function automatic logic [Q_WIDTH+DATA_W-1:0] snoop(
    input logic [Q_WIDTH-1:0] q,     input logic [DATA_W-1:0]  v,
    input logic               a_vld, input logic [Q_WIDTH-1:0] a_tag,
    input logic [DATA_W-1:0]  a_val, input logic               l_vld,
    input logic [Q_WIDTH-1:0] l_tag, input logic [DATA_W-1:0]  l_val);
    if (cdb_hit(q, a_vld, a_tag)) return {QZ, a_val};
    if (cdb_hit(q, l_vld, l_tag)) return {QZ, l_val};
    return {q, v};
  endfunction

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] && (q1_q[i] == QZ) && (q2_q[i] == QZ);
    end
  end

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
    .req   (~busy),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_disp (
    .req   (ready_vec),
    .found (disp_found),
    .idx   (disp_idx)
  );

  // A slot freed by this cycle's dispatch is not counted as free until next cycle.
  assign full       = &busy;
  assign issue_fire = bus.issue_valid_in && !full && free_found;

  // Stage p0 -> entry storage: operand wakeup and issue write (no reset needed).
  always_ff @(posedge clk_in) begin
    if (rdy_in && !clear_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i]) begin
          {q1_q[i], v1_q[i]} <= snoop(q1_q[i], v1_q[i], alu_vld, alu_tag, alu_val,
                                      lsb_vld, lsb_tag, lsb_val);
          {q2_q[i], v2_q[i]} <= snoop(q2_q[i], v2_q[i], alu_vld, alu_tag, alu_val,
                                      lsb_vld, lsb_tag, lsb_val);
        end
      end
      if (issue_fire) begin
        op_q[free_idx]   <= bus.issue_op_in;
        imm_q[free_idx]  <= bus.issue_imm_in;
        npc_q[free_idx]  <= bus.issue_npc_in;
        dest_q[free_idx] <= bus.issue_dest_in;
        {q1_q[free_idx], v1_q[free_idx]} <= snoop(bus.issue_Q1_in, bus.issue_V1_in,
          alu_vld, alu_tag, alu_val, lsb_vld, lsb_tag, lsb_val);
        {q2_q[free_idx], v2_q[free_idx]} <= snoop(bus.issue_Q2_in, bus.issue_V2_in,
          alu_vld, alu_tag, alu_val, lsb_vld, lsb_tag, lsb_val);
      end
    end
  end

  // Stage p1: occupancy and registered dispatch to EX.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy    <= '0;
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      v1_p1   <= '0;
      v2_p1   <= '0;
      imm_p1  <= '0;
      npc_p1  <= '0;
      dest_p1 <= '0;
    end else if (clear_in) begin
      busy   <= '0;
      vld_p1 <= 1'b0;
    end else if (rdy_in) begin
      if (disp_found) begin
        busy[disp_idx] <= 1'b0;
        vld_p1  <= 1'b1;
        op_p1   <= op_q[disp_idx];
        v1_p1   <= v1_q[disp_idx];
        v2_p1   <= v2_q[disp_idx];
        imm_p1  <= imm_q[disp_idx];
        npc_p1  <= npc_q[disp_idx];
        dest_p1 <= dest_q[disp_idx];
      end else begin
        vld_p1 <= 1'b0;
      end
      if (issue_fire) begin
        busy[free_idx] <= 1'b1;
      end
    end
  end

  assign bus.full_out     = full;
  assign bus.ex_valid_out = vld_p1;
  assign bus.ex_op_out    = op_p1;
  assign bus.ex_V1_out    = v1_p1;
  assign bus.ex_V2_out    = v2_p1;
  assign bus.ex_imm_out   = imm_p1;
  assign bus.ex_npc_out   = npc_p1;
  assign bus.ex_dest_out  = dest_p1;

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: issue, wakeup, bypass, ordering/full, flush,
// stall and mid-run reset, all with hand-computed expectations.
module tb_rs_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int checks = 0;
  int failures = 0;

  rs_alu_if #(.Q_WIDTH(5)) bus ();

  rs_alu #(.RS_SIZE(16), .Q_WIDTH(5)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear_in (clear),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] tag, input logic [31:0] val);
    bus.alu_cdb_valid_in = v;
    bus.alu_cdb_tag_in   = tag;
    bus.alu_cdb_value_in = val;
  endtask

  task automatic set_lsb(input logic v, input logic [4:0] tag, input logic [31:0] val);
    bus.lsb_cdb_valid_in = v;
    bus.lsb_cdb_tag_in   = tag;
    bus.lsb_cdb_value_in = val;
  endtask

  task automatic do_issue(input logic [9:0] op, input logic [31:0] v1, input logic [4:0] q1,
                          input logic [31:0] v2, input logic [4:0] q2,
                          input logic [31:0] imm, input logic [31:0] npc,
                          input logic [4:0] dest);
    bus.issue_valid_in = 1'b1;
    bus.issue_op_in    = op;
    bus.issue_V1_in    = v1;
    bus.issue_Q1_in    = q1;
    bus.issue_V2_in    = v2;
    bus.issue_Q2_in    = q2;
    bus.issue_imm_in   = imm;
    bus.issue_npc_in   = npc;
    bus.issue_dest_in  = dest;
    tick();
    bus.issue_valid_in = 1'b0;
  endtask

  task automatic chk_disp(input string tag, input logic [4:0] dest, input logic [31:0] v1);
    check_eq({tag, "_vld"}, 32'(bus.ex_valid_out), 32'd1);
    check_eq({tag, "_dest"}, 32'(bus.ex_dest_out), 32'(dest));
    check_eq({tag, "_v1"}, bus.ex_V1_out, v1);
  endtask

  task automatic chk_idle(input string tag);
    check_eq({tag, "_idle"}, 32'(bus.ex_valid_out), 32'd0);
  endtask

  initial begin
    bus.issue_valid_in = 1'b0;
    bus.issue_op_in = '0;   bus.issue_V1_in = '0;  bus.issue_Q1_in = '0;
    bus.issue_V2_in = '0;   bus.issue_Q2_in = '0;  bus.issue_imm_in = '0;
    bus.issue_npc_in = '0;  bus.issue_dest_in = '0;
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);

    // Power-on reset
    tick(); tick();
    rst_n = 1'b1;
    check_eq("rst_vld", 32'(bus.ex_valid_out), 32'd0);
    check_eq("rst_full", 32'(bus.full_out), 32'd0);
    check_eq("rst_dest", 32'(bus.ex_dest_out), 32'd0);
    check_eq("rst_v1", bus.ex_V1_out, 32'd0);

    // Ready issue: dispatch after the following edge, then idle with held data
    do_issue(10'h080, 32'd5, 5'd0, 32'd7, 5'd0, 32'h1234, 32'h400, 5'd4);
    chk_idle("rdy_t");
    tick();
    chk_disp("rdy_t1", 5'd4, 32'd5);
    check_eq("rdy_v2", bus.ex_V2_out, 32'd7);
    check_eq("rdy_op", 32'(bus.ex_op_out), 32'h080);
    check_eq("rdy_imm", bus.ex_imm_out, 32'h1234);
    check_eq("rdy_npc", bus.ex_npc_out, 32'h400);
    tick();
    chk_idle("rdy_t2");
    check_eq("rdy_hold_v1", bus.ex_V1_out, 32'd5);

    // ALU CDB wakeup
    do_issue(10'h081, 32'd0, 5'd3, 32'd9, 5'd0, 32'd0, 32'h404, 5'd5);
    tick();
    chk_idle("alu_wait");
    set_alu(1'b1, 5'd3, 32'h10);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    chk_idle("alu_k");
    tick();
    chk_disp("alu_k1", 5'd5, 32'h10);
    check_eq("alu_v2", bus.ex_V2_out, 32'd9);
    tick();
    chk_idle("alu_after");

    // LSB CDB wakeup
    do_issue(10'h082, 32'd0, 5'd6, 32'd3, 5'd0, 32'd0, 32'h408, 5'd6);
    chk_idle("lsb_wait");
    set_lsb(1'b1, 5'd6, 32'h20);
    tick();
    set_lsb(1'b0, 5'd0, 32'd0);
    chk_idle("lsb_k");
    tick();
    chk_disp("lsb_k1", 5'd6, 32'h20);

    // Issue bypass on both operands, one from each CDB
    set_alu(1'b1, 5'd2, 32'h33);
    set_lsb(1'b1, 5'd11, 32'h44);
    do_issue(10'h083, 32'd0, 5'd2, 32'd0, 5'd11, 32'd0, 32'h40c, 5'd7);
    set_alu(1'b0, 5'd0, 32'd0);
    set_lsb(1'b0, 5'd0, 32'd0);
    chk_idle("byp_t");
    tick();
    chk_disp("byp_t1", 5'd7, 32'h33);
    check_eq("byp_v2", bus.ex_V2_out, 32'h44);
    tick();

    // Fill all 16 entries, drop a 17th, then drain in index order
    for (int i = 0; i < 16; i++) begin
      do_issue(10'h100, 32'd0, 5'd7, 32'd1, 5'd0, 32'd0, 32'd0, 5'(i + 1));
    end
    check_eq("full_set", 32'(bus.full_out), 32'd1);
    do_issue(10'h100, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 32'd0, 5'd20);
    chk_idle("full_drop");
    set_alu(1'b1, 5'd7, 32'h70);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    chk_idle("full_k");
    check_eq("full_k_full", 32'(bus.full_out), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk_disp($sformatf("drain%0d", i), 5'(i), 32'h70);
      if (i == 1) check_eq("full_fall", 32'(bus.full_out), 32'd0);
    end
    tick();
    chk_idle("drain_end");

    // Flush with four busy entries, one of them selected
    do_issue(10'h101, 32'd0, 5'd8, 32'd0, 5'd0, 32'd0, 32'd0, 5'd2);
    do_issue(10'h101, 32'd0, 5'd8, 32'd0, 5'd0, 32'd0, 32'd0, 5'd3);
    do_issue(10'h101, 32'd0, 5'd8, 32'd0, 5'd0, 32'd0, 32'd0, 5'd4);
    do_issue(10'h101, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd1);
    clear = 1'b1;
    do_issue(10'h101, 32'd2, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd9);
    clear = 1'b0;
    chk_idle("flush_t1");
    check_eq("flush_full", 32'(bus.full_out), 32'd0);
    tick();
    chk_idle("flush_t2");
    set_alu(1'b1, 5'd8, 32'h88);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk_idle("flush_woke1");
    tick();
    chk_idle("flush_woke2");
    do_issue(10'h101, 32'd3, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd10);
    tick();
    chk_disp("flush_post", 5'd10, 32'd3);
    tick();

    // Stall: rdy low with one dispatch on the outputs and a CDB broadcast
    do_issue(10'h102, 32'd0, 5'd12, 32'd0, 5'd0, 32'd0, 32'd0, 5'd13);
    do_issue(10'h102, 32'd14, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd14);
    do_issue(10'h102, 32'd15, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd15);
    chk_disp("stall_pre", 5'd14, 32'd14);
    rdy = 1'b0;
    set_alu(1'b1, 5'd12, 32'h12);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_disp($sformatf("stall%0d", i), 5'd14, 32'd14);
    end
    rdy = 1'b1;
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk_disp("stall_resume", 5'd15, 32'd15);
    tick();
    chk_idle("stall_unwoken");
    set_alu(1'b1, 5'd12, 32'h12);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    tick();
    chk_disp("stall_late", 5'd13, 32'h12);
    tick();

    // Mid-run asynchronous reset with three waiting entries
    do_issue(10'h103, 32'd0, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0, 5'd1);
    do_issue(10'h103, 32'd0, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0, 5'd2);
    do_issue(10'h103, 32'd0, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0, 5'd3);
    #2 rst_n = 1'b0;
    #2;
    check_eq("mrst_async_dest", 32'(bus.ex_dest_out), 32'd0);
    rst_n = 1'b1;
    tick();
    chk_idle("mrst_vld");
    check_eq("mrst_full", 32'(bus.full_out), 32'd0);
    set_alu(1'b1, 5'd9, 32'h99);
    tick();
    set_alu(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("mrst%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station for the ALU/branch/jump execution unit in the Tomasulo core.
- Accepts renamed instructions from the issue stage and holds them until both operands are ready.
- Snoops two common data buses (ALU and LSB) for operand wakeup.
- Dispatches at most one ready instruction per cycle to the combinational EX unit through registered outputs (op, V1, V2, immediate, npc, dest tag).

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- Q_WIDTH, 5, ROB tag width. Tag 0 means "no dependency / value valid".

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global ready; low freezes all state and outputs
- clear_in  input  1  mispredict flush
- issue_valid_in  input  1  issue request
- issue_op_in  input  10  op code: [9:7] class, [6:4] sub, [3:0] funct
- issue_V1_in  input  32  rs1 value
- issue_Q1_in  input  Q_WIDTH  rs1 tag
- issue_V2_in  input  32  rs2 value
- issue_Q2_in  input  Q_WIDTH  rs2 tag
- issue_imm_in  input  32  immediate
- issue_npc_in  input  32  instruction pc
- issue_dest_in  input  Q_WIDTH  ROB destination tag
- full_out  output  1  no free entry
- alu_cdb_valid_in  input  1  ALU CDB broadcast valid
- alu_cdb_tag_in  input  Q_WIDTH  ALU CDB tag
- alu_cdb_value_in  input  32  ALU CDB value
- lsb_cdb_valid_in  input  1  LSB CDB broadcast valid
- lsb_cdb_tag_in  input  Q_WIDTH  LSB CDB tag
- lsb_cdb_value_in  input  32  LSB CDB value
- ex_valid_out  output  1  dispatch valid this cycle
- ex_op_out  output  10  op to EX
- ex_V1_out  output  32  operand 1 to EX
- ex_V2_out  output  32  operand 2 to EX
- ex_imm_out  output  32  immediate to EX
- ex_npc_out  output  32  pc to EX
- ex_dest_out  output  Q_WIDTH  ROB tag of the dispatched instruction

Behaviour:
- Reset (async, rst_n_in low):
  - all entry busy bits 0.
  - every ex_* output 0.
  - full_out 0.
- Entry fields: busy, op, V1, Q1, V2, Q2, imm, npc, dest.
- Priority each rising edge: clear_in > rdy_in low > normal operation.
- clear_in=1: all busy bits 0, ex_valid_out 0 next cycle. Issue and CDB inputs are ignored that cycle.
- rdy_in=0 (and no clear): no state change; all outputs hold their values.
- Issue:
  - If issue_valid_in and not full_out, write the lowest-index free entry.
  - Issuing while full_out is high is ignored. The issue stage must not do it.
- Issue bypass: if issue_Qk matches a valid CDB tag (nonzero) in the same cycle, store the CDB value and set Qk=0.
- Wakeup: for every busy entry and k in {1,2}, if Qk!=0 and Qk equals a valid CDB tag, set Vk=value and Qk=0.
  - Both CDBs are checked independently.
  - Both CDBs carrying the same tag is illegal; if it happens, ALU wins.
- CDB tag 0 is never matched.
- Select:
  - Combinational over the registered state: lowest-index entry with busy && Q1==0 && Q2==0.
  - Entries written or woken this cycle become eligible next cycle.
- Dispatch:
  - At the edge, if a selected entry exists, register its fields onto ex_*, set ex_valid_out=1, and clear its busy bit. Otherwise ex_valid_out=0 and the other ex_* outputs hold.
  - Minimum latency: issue edge t with ready operands -> ex_valid_out high after edge t+1.
  - Wakeup edge k -> dispatch after edge k+1.
- full_out: combinational, equals (busy count == RS_SIZE). It ignores a slot freed by a same-cycle dispatch (conservative).
- Simultaneous events:
  - Issue and dispatch in the same cycle are independent.
  - The freed slot is reusable from the next cycle.
- op is carried opaquely; this block does not decode it.

Decomposition:
- Shared package (cpu_defs), holding:
  - op class constants: OP_R=1, OP_I=2, OP_B=4, OP_U=5, OP_J=6.
  - Q_NONE=0.
  - default RS_SIZE and Q_WIDTH.
- One sub-module, rs_pick: a parameterised lowest-index priority encoder. Instantiate it twice:
  - busy-free vector -> issue slot.
  - ready vector -> dispatch slot.
- Each instance outputs found and an index.

Test Plan:
- Reset: hold rst_n_in low mid-run with 3 entries busy -> after release, ex_valid_out=0, full_out=0, no dispatch in the next 5 cycles.
- Ready issue: op=0x080, V1=5, V2=7, Q1=Q2=0, dest=4 at edge t -> after edge t+1: ex_valid_out=1, ex_V1_out=5, ex_V2_out=7, ex_dest_out=4. At t+2, ex_valid_out=0.
- Wakeup: issue Q1=3, V2=9, Q2=0; later ALU CDB tag=3, value=0x10 at edge k -> dispatch after edge k+1 with V1=0x10. No dispatch before.
  - Repeat with LSB CDB.
  - Repeat with the broadcast coinciding with the issue edge (bypass): dispatch after issue edge+1.
- Order/full: issue 16 entries with Q1=7 -> full_out=1, 17th issue dropped. Then broadcast tag 7 -> 16 dispatches on consecutive cycles in index order (dests 1..16); full_out falls after the first dispatch.
- Flush: 4 busy entries, one selected; clear_in=1 -> ex_valid_out=0 next cycle, full_out=0. Same-cycle issue lost, subsequent issue dispatches normally.
- rdy_in low 3 cycles with a ready entry and a CDB broadcast -> outputs and entries unchanged; dispatch resumes the cycle after rdy_in returns high.
